grid_server: RTL and testbench

Owner of the 40x30 level grid and the responder end of the grid access interface used by the enemy updater, player updater and renderer. It holds one 3-bit cell per grid square and initialises the grid to an empty walled level after reset. It grants exclusive access to one client at a time with round-robin arbitration. The granted client's read address is served combinationally, and its writes commit on the clock edge.

---
 rtl/grid_pkg.sv | 24 ++
 rtl/grid_server_if.sv | 22 ++
 rtl/grid_rr_arbiter.sv | 30 +++
 rtl/grid_server.sv | 157 +++++++++++++++
 tb/tb_grid_server.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/grid_pkg.sv
// Shared constants, cell codes and FSM encodings for the 40x30 level grid.
package grid_pkg;

    localparam int GRID_W     = 40;
    localparam int GRID_H     = 30;
    localparam int GRID_CELLS = 1200;
    localparam int CELL_BITS  = 3;

    typedef logic [CELL_BITS-1:0] cell_t;

    localparam cell_t CELL_AIR   = 3'd0;
    localparam cell_t CELL_WALL  = 3'd1;
    localparam cell_t CELL_ENEMY = 3'd4;

    localparam logic [1:0] ST_INIT  = 2'd0;
    localparam logic [1:0] ST_IDLE  = 2'd1;
    localparam logic [1:0] ST_GRANT = 2'd2;

    // Row-major cell address; out-of-range coordinates still fit in 11 bits.
    function automatic logic [10:0] cell_addr(input logic [5:0] x, input logic [4:0] y);
        return 11'(y) * 11'(GRID_W) + 11'(x);
    endfunction

endpackage

// File: rtl/grid_server_if.sv
// Grid access bus between the clients (master side) and the grid server (slave side).
interface grid_server_if #(parameter int NUM_CLIENTS = 3);
    import grid_pkg::*;

    logic [NUM_CLIENTS-1:0]   client_req;
    logic [NUM_CLIENTS-1:0]   client_gnt;
    logic [6*NUM_CLIENTS-1:0] client_x;
    logic [5*NUM_CLIENTS-1:0] client_y;
    logic [NUM_CLIENTS-1:0]   client_write;
    logic [3*NUM_CLIENTS-1:0] client_in;
    cell_t                    grid_out;

    modport master (
        output client_req, client_x, client_y, client_write, client_in,
        input  client_gnt, grid_out
    );

    modport slave (
        input  client_req, client_x, client_y, client_write, client_in,
        output client_gnt, grid_out
    );
endinterface

// File: rtl/grid_rr_arbiter.sv
// Combinational round-robin pick: first requester strictly after last_owner, wrapping.
module grid_rr_arbiter #(
    parameter int NUM_CLIENTS = 3,
    parameter int OW          = 2
) (
    input  logic [NUM_CLIENTS-1:0] req,
    input  logic [OW-1:0]          last_owner,
    output logic [NUM_CLIENTS-1:0] next_gnt,
    output logic                   any_req
);

    int   idx;
    logic found;

    always_comb begin
        next_gnt = '0;
        any_req  = |req;
        found    = 1'b0;
        idx      = 0;
        // Offset NUM_CLIENTS lands on last_owner itself, so it only wins when alone.
        for (int k = 1; k <= NUM_CLIENTS; k++) begin
            idx = (int'(last_owner) + k) % NUM_CLIENTS;
            if (!found && req[idx]) begin
                next_gnt[idx] = 1'b1;
                found         = 1'b1;
            end
        end
    end

endmodule

// File: rtl/grid_server.sv
// Owner of the level grid: sweeps a walled empty level after reset, then serves one
// round-robin-granted client at a time with asynchronous reads and clocked writes.
module grid_server
    import grid_pkg::*;
#(
    parameter int NUM_CLIENTS = 3
) (
    input  logic          clock,
    input  logic          reset,
    grid_server_if.slave  bus,
    output logic          init_done
);

    localparam int OW = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;

    logic [1:0]             state_reg;
    logic [5:0]             init_x_reg;
    logic [4:0]             init_y_reg;
    logic [NUM_CLIENTS-1:0] gnt_reg;
    logic [OW-1:0]          owner_reg;
    logic [OW-1:0]          last_owner_reg;
    logic                   init_done_reg;

    cell_t mem [0:GRID_CELLS-1];

    logic [5:0] cx   [NUM_CLIENTS];
    logic [4:0] cy   [NUM_CLIENTS];
    cell_t      cdat [NUM_CLIENTS];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CLIENTS; gi++) begin : g_unpack
            assign cx[gi]   = bus.client_x[6*gi +: 6];
            assign cy[gi]   = bus.client_y[5*gi +: 5];
            assign cdat[gi] = bus.client_in[3*gi +: 3];
        end
    endgenerate

    logic [NUM_CLIENTS-1:0] next_gnt;
    logic                   any_req;
    logic [OW-1:0]          next_owner;

    grid_rr_arbiter #(
        .NUM_CLIENTS (NUM_CLIENTS),
        .OW          (OW)
    ) u_arb (
        .req        (bus.client_req),
        .last_owner (last_owner_reg),
        .next_gnt   (next_gnt),
        .any_req    (any_req)
    );

    always_comb begin
        next_owner = '0;
        for (int i = 0; i < NUM_CLIENTS; i++) begin
            if (next_gnt[i]) next_owner = OW'(i);
        end
    end

    logic [5:0]  own_x;
    logic [4:0]  own_y;
    cell_t       own_in;
    logic        own_req;
    logic        own_write;
    logic        in_range;
    logic [10:0] own_addr;
    logic [10:0] init_addr;
    cell_t       init_cell;

    assign own_x     = cx[owner_reg];
    assign own_y     = cy[owner_reg];
    assign own_in    = cdat[owner_reg];
    assign own_req   = bus.client_req[owner_reg];
    assign own_write = bus.client_write[owner_reg];
    assign in_range  = (own_x < 6'(GRID_W)) && (own_y < 5'(GRID_H));
    assign own_addr  = cell_addr(own_x, own_y);
    assign init_addr = cell_addr(init_x_reg, init_y_reg);
    assign init_cell = (init_x_reg == 6'd0 || init_x_reg == 6'(GRID_W-1) ||
                        init_y_reg == 5'd0 || init_y_reg == 5'(GRID_H-1)) ? CELL_WALL : CELL_AIR;

    logic        mem_we;
    logic [10:0] mem_addr;
    cell_t       mem_wdata;

    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = init_addr;
        mem_wdata = init_cell;
        if (state_reg == ST_INIT) begin
            mem_we = 1'b1;
        end else if (state_reg == ST_GRANT && own_write && in_range) begin
            mem_we    = 1'b1;
            mem_addr  = own_addr;
            mem_wdata = own_in;
        end
    end

    always_ff @(posedge clock) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
    end

    // Out-of-range squares read as WALL so movers treat the border as solid.
    always_comb begin
        bus.grid_out = CELL_AIR;
        if (state_reg == ST_GRANT) begin
            bus.grid_out = in_range ? mem[own_addr] : CELL_WALL;
        end
    end

    assign bus.client_gnt = gnt_reg;
    assign init_done      = init_done_reg;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg      <= ST_INIT;
            init_x_reg     <= '0;
            init_y_reg     <= '0;
            gnt_reg        <= '0;
            owner_reg      <= '0;
            last_owner_reg <= OW'(NUM_CLIENTS-1);
            init_done_reg  <= 1'b0;
        end else begin
            case (state_reg)
                ST_INIT: begin
                    if (init_x_reg == 6'(GRID_W-1)) begin
                        init_x_reg <= '0;
                        if (init_y_reg == 5'(GRID_H-1)) begin
                            init_y_reg    <= '0;
                            state_reg     <= ST_IDLE;
                            init_done_reg <= 1'b1;
                        end else begin
                            init_y_reg <= init_y_reg + 5'd1;
                        end
                    end else begin
                        init_x_reg <= init_x_reg + 6'd1;
                    end
                end
                ST_IDLE: begin
                    if (any_req) begin
                        gnt_reg        <= next_gnt;
                        owner_reg      <= next_owner;
                        last_owner_reg <= next_owner;
                        state_reg      <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    if (!own_req) begin
                        gnt_reg   <= '0;
                        state_reg <= ST_IDLE;
                    end
                end
                default: state_reg <= ST_INIT;
            endcase
        end
    end

endmodule

// File: tb/tb_grid_server.sv
// Self-checking bench for grid_server: directed vector table, handover/reset sequences,
// and randomized transactions scored against a cell-array reference model.
module tb_grid_server;
    import grid_pkg::*;

    logic clock = 1'b0;
    logic reset;
    logic init_done;

    always #10 clock = ~clock;

    grid_server_if #(.NUM_CLIENTS(3)) bus ();

    grid_server #(.NUM_CLIENTS(3)) dut (
        .clock     (clock),
        .reset     (reset),
        .bus       (bus),
        .init_done (init_done)
    );

    int n_checks = 0;
    int n_pass   = 0;

    logic [2:0] ref_mem [0:39][0:29];

    typedef struct {
        int x;
        int y;
        int exp;
    } rd_vec_t;

    rd_vec_t vecs [10];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_client(input int c, input int x, input int y, input int w, input int d);
        bus.client_x[c*6 +: 6]   = 6'(x);
        bus.client_y[c*5 +: 5]   = 5'(y);
        bus.client_write[c]      = w[0];
        bus.client_in[c*3 +: 3]  = 3'(d);
    endtask

    task automatic ref_init();
        for (int x = 0; x < 40; x++)
            for (int y = 0; y < 30; y++)
                ref_mem[x][y] = (x == 0 || x == 39 || y == 0 || y == 29) ? 3'd1 : 3'd0;
    endtask

    function automatic int exp_read(input int x, input int y);
        if (x > 39 || y > 29) return 1;
        return int'(ref_mem[x][y]);
    endfunction

    function automatic int rr_pick(input logic [2:0] r, input int last);
        for (int k = 1; k <= 3; k++) begin
            if (r[(last + k) % 3]) return (last + k) % 3;
        end
        return -1;
    endfunction

    task automatic wait_init(input string name);
        int cnt;
        cnt = 0;
        while (!init_done && cnt < 2000) begin
            tick();
            cnt++;
            if (cnt == 600) bus.client_req = 3'b101;
            if (cnt == 1199) check({name, "_gnt_in_init"}, int'(bus.client_gnt), 0);
        end
        check({name, "_cycles"}, cnt, 1200);
        check({name, "_gnt_at_idle"}, int'(bus.client_gnt), 0);
    endtask

    initial begin
        int errs;
        int w;
        int nops;
        int x, y, wr, d;
        logic [2:0] r;
        int model_last;

        vecs[0] = '{0, 0, 1};
        vecs[1] = '{39, 29, 1};
        vecs[2] = '{20, 0, 1};
        vecs[3] = '{5, 5, 0};
        vecs[4] = '{38, 28, 0};
        vecs[5] = '{40, 3, 1};
        vecs[6] = '{3, 30, 1};
        vecs[7] = '{63, 31, 1};
        vecs[8] = '{0, 15, 1};
        vecs[9] = '{39, 15, 1};

        reset = 1'b1;
        bus.client_req = '0;
        bus.client_x = '0;
        bus.client_y = '0;
        bus.client_write = '0;
        bus.client_in = '0;
        tick();
        tick();
        check("reset_gnt", int'(bus.client_gnt), 0);
        check("reset_grid_out", int'(bus.grid_out), 0);
        check("reset_init_done", int'(init_done), 0);

        // Requests raised mid-INIT must be served (client 0 first) once INIT ends.
        reset = 1'b0;
        wait_init("init1");
        ref_init();
        tick();
        check("init_req_served", int'(bus.client_gnt), 1);
        $display("txn: client 0 granted after init");

        for (int i = 0; i < 10; i++) begin
            set_client(0, vecs[i].x, vecs[i].y, 0, 0);
            #1;
            check($sformatf("vec_read_%0d", i), int'(bus.grid_out), vecs[i].exp);
            tick();
        end

        set_client(0, 10, 10, 1, 4);
        #1;
        check("wr_cycle_old", int'(bus.grid_out), 0);
        tick();
        set_client(0, 10, 10, 0, 0);
        #1;
        check("wr_next_new", int'(bus.grid_out), 4);
        ref_mem[10][10] = 3'd4;

        bus.client_req[0] = 1'b0;
        tick();
        check("release0", int'(bus.client_gnt), 0);
        tick();
        check("handover_to2", int'(bus.client_gnt), 4);
        $display("txn: client 2 granted after handover");
        set_client(2, 10, 10, 0, 0);
        #1;
        check("c2_reads_10_10", int'(bus.grid_out), 4);

        set_client(2, 63, 31, 1, 4);
        tick();
        set_client(2, 0, 0, 0, 0);
        errs = 0;
        for (int xx = 0; xx < 40; xx++) begin
            for (int yy = 0; yy < 30; yy++) begin
                set_client(2, xx, yy, 0, 0);
                #1;
                if (int'(bus.grid_out) != exp_read(xx, yy)) errs++;
            end
        end
        check("oob_write_scan_errs", errs, 0);
        bus.client_req = '0;
        tick();
        check("release2", int'(bus.client_gnt), 0);

        bus.client_req[1] = 1'b1;
        set_client(1, 7, 7, 0, 0);
        tick();
        check("c1_grant", int'(bus.client_gnt), 2);
        bus.client_req[2] = 1'b1;
        set_client(2, 7, 7, 1, 4);
        tick();
        check("intruder_gnt", int'(bus.client_gnt), 2);
        tick();
        check("intruder_no_write", int'(bus.grid_out), 0);
        bus.client_req = '0;
        set_client(2, 7, 7, 0, 0);
        tick();
        check("release1", int'(bus.client_gnt), 0);
        $display("txn: client 1 owner, client 2 write ignored");

        bus.client_req = 3'b101;
        tick();
        check("rr_last1_picks2", int'(bus.client_gnt), 4);
        #1;
        check("c2_reads_7_7", int'(bus.grid_out), 0);
        bus.client_req = '0;
        tick();
        tick();
        bus.client_req = 3'b101;
        tick();
        check("rr_last2_picks0", int'(bus.client_gnt), 1);
        bus.client_req = '0;
        tick();
        tick();

        bus.client_req[1] = 1'b1;
        #3;
        bus.client_req[1] = 1'b0;
        tick();
        check("short_pulse_no_grant", int'(bus.client_gnt), 0);

        model_last = 0;
        for (int t = 0; t < 40; t++) begin
            r = 3'($urandom_range(1, 7));
            w = rr_pick(r, model_last);
            bus.client_req = r;
            tick();
            check("rnd_grant", int'(bus.client_gnt), 1 << w);
            model_last = w;
            nops = $urandom_range(1, 6);
            for (int k = 0; k < nops; k++) begin
                for (int c = 0; c < 3; c++) begin
                    if (c != w)
                        set_client(c, $urandom_range(0, 45), $urandom_range(0, 31), 1,
                                   $urandom_range(0, 7));
                end
                x = $urandom_range(0, 45);
                y = $urandom_range(0, 31);
                wr = $urandom_range(0, 1);
                d = $urandom_range(0, 7);
                set_client(w, x, y, wr, d);
                #1;
                check("rnd_read", int'(bus.grid_out), exp_read(x, y));
                tick();
                if (wr != 0 && x <= 39 && y <= 29) ref_mem[x][y] = 3'(d);
            end
            bus.client_write = '0;
            bus.client_req = '0;
            tick();
            check("rnd_release", int'(bus.client_gnt), 0);
            $display("txn %0d: req=%b owner=%0d ops=%0d", t, r, w, nops);
        end

        bus.client_req = 3'b001;
        tick();
        check("pre_reset_grant", int'(bus.client_gnt), 1);
        set_client(0, 12, 12, 1, 4);
        tick();
        set_client(0, 12, 12, 0, 0);
        #1;
        check("pre_reset_read", int'(bus.grid_out), 4);
        reset = 1'b1;
        tick();
        check("midgrant_reset_gnt", int'(bus.client_gnt), 0);
        check("midgrant_reset_init_done", int'(init_done), 0);
        check("midgrant_reset_grid_out", int'(bus.grid_out), 0);
        reset = 1'b0;
        bus.client_req = 3'b001;
        wait_init("init2");
        tick();
        check("post_reset_grant", int'(bus.client_gnt), 1);
        set_client(0, 12, 12, 0, 0);
        #1;
        check("reinit_12_12", int'(bus.grid_out), 0);
        set_client(0, 0, 0, 0, 0);
        #1;
        check("reinit_0_0", int'(bus.grid_out), 1);
        $display("txn: reset mid-grant and re-init");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
